ring_recirc_pipeline: RTL and testbench
=======================================

# ring_recirc_pipeline

Parametrised circular datapath: a ring of STAGES registered hop stages in which every packet circulates for a programmable number of laps before being ejected through a single registered output port. It generalises our fixed hand-wired circular instance graphs into one block with configurable width, ring depth and lap count, and adds valid/ready handshakes, backpressure-driven recirculation and occupancy tracking. It sits between a packet source and a consumer, acting as a deterministic delay-and-transform loop.

## Interface
- WIDTH, 8: data width in bits.
- STAGES, 4: number of ring slots; must be at least 2.
- LAP_W, 4: width of the per-packet lap counter.
- clk  input  1  the single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  source presents a packet.
- in_ready  output  1  ring accepts the packet this cycle.
- in_data  input  WIDTH  packet payload.
- in_laps  input  LAP_W  laps to complete before ejection; 0 is treated as 1.
- out_valid  output  1  output register holds a packet.
- out_ready  input  1  consumer accepts the output packet.
- out_data  output  WIDTH  ejected payload.
- occupancy  output  clog2(STAGES+1)  number of valid ring slots, output register excluded.

## Operation
- State: slots s[0..STAGES-1], each {v, data, laps}, plus the output register {out_valid, out_data}.
- Every cycle the ring rotates unconditionally: s[i] <= hop(s[i-1]) for i = 1..STAGES-1. hop() increments data by 1 modulo 2^WIDTH and copies v and laps.
- Wrap slot w = hop(s[STAGES-1]) with laps decremented, saturating at 0.
- Output space: out_free = !out_valid || out_ready.
- Eject: when w.v, w.laps == 0 and out_free, w.data loads into the output register and out_valid is set. Otherwise, if out_free, out_valid clears.
- Blocked: when w.v, w.laps == 0 and !out_free, w re-enters s[0] with laps 0 and is retried on every later lap. It is never dropped.
- in_ready = !w.v || (w.laps == 0 && out_free). This is combinational from out_ready and the registered state.
- Accept (in_valid && in_ready): s[0] <= {1, in_data, max(in_laps,1)}. The payload is not incremented on injection.
- Otherwise s[0] <= w if w is valid and not ejected, else s[0] is invalid.
- occupancy is the registered count of valid slots, updated every edge.
- Packet order is preserved among packets with equal lap counts. Packets with different lap counts may overtake each other.

## Timing
- Reset (synchronous, takes priority over all other updates): every slot invalid with data and laps 0, out_valid 0, out_data 0, occupancy 0. in_ready is therefore 1 in the first cycle after reset.
- A packet accepted at edge t occupies s[k] after edge t+k.
- An unstalled packet with L laps reaches the wrap decision during the cycle ending at edge t+L*STAGES and loads the output register at that edge.
- out_data = in_data + STAGES*(L+R) mod 2^WIDTH, where R is the number of blocked retries.
- Throughput: at most one accept and one eject per cycle. An eject and an accept in the same cycle are legal; the freed slot is refilled immediately.
- Full ring: all slots valid and the wrap packet not ejectable, so in_ready stays 0 until an eject frees the wrap slot.
- Reset asserted mid-operation discards every in-flight packet and the output register with no output handshake.

## Test plan
- Set STAGES=4, WIDTH=8. Inject 0x10 with L=1 at edge t, holding out_ready=1. Require out_valid=1 and out_data=0x14 after edge t+4, and out_valid=0 one cycle later.
- Inject 0xFE with L=3. Require the output at edge t+12 with out_data=0x0A (wrap-around), and occupancy=1 throughout transit.
- Inject A=0x00 at t and B=0x20 at t+1, both L=1, with out_ready=0. Require A to load the output register at t+4 as 0x04. Require B to be blocked at t+5 and recirculate. Raise out_ready at t+6: A is consumed, and B ejects at t+9 as 0x28.
- Inject four back-to-back packets with L=2. Require occupancy=4 and in_ready=0 from t+4 through t+7, then one eject per cycle at t+8..t+11 with in_ready=1 again.
- Inject with L=0. Require behaviour identical to L=1: output at t+4 with data+4.
- Assert rst for one cycle with three packets in flight and out_valid=1. Require all outputs at reset values after that edge and no later output.

Source files
------------

// File: rtl/ring_recirc_pipeline.sv
// Circular datapath: packets hop around a ring of registered slots, gaining +1 per hop,
// and leave through one registered output port after a programmable number of laps.
module ring_recirc_pipeline #(
    parameter  int WIDTH  = 8,
    parameter  int STAGES = 4,
    parameter  int LAP_W  = 4,
    localparam int OCC_W  = $clog2(STAGES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [LAP_W-1:0] in_laps,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);

    logic             r_v    [STAGES];
    logic [WIDTH-1:0] r_data [STAGES];
    logic [LAP_W-1:0] r_laps [STAGES];
    logic             r_outValid;
    logic [WIDTH-1:0] r_outData;
    logic [OCC_W-1:0] r_occupancy;

    logic             w_wrapValid;
    logic [WIDTH-1:0] w_wrapData;
    logic [LAP_W-1:0] w_wrapLaps;
    logic             w_outFree;
    logic             w_eject;
    logic             w_accept;
    logic             w_s0Valid;
    logic [WIDTH-1:0] w_s0Data;
    logic [LAP_W-1:0] w_s0Laps;
    logic [OCC_W-1:0] w_occNext;

    // The wrap slot is the packet leaving the last stage; it is either ejected,
    // recirculated into slot 0, or displaced by nothing (its slot is free for injection).
    always_comb begin
        w_wrapValid = r_v[STAGES-1];
        w_wrapData  = r_data[STAGES-1] + WIDTH'(1);
        w_wrapLaps  = (r_laps[STAGES-1] == '0) ? '0 : r_laps[STAGES-1] - LAP_W'(1);
        w_outFree   = !r_outValid || out_ready;
        w_eject     = w_wrapValid && (w_wrapLaps == '0) && w_outFree;
        w_accept    = in_valid && in_ready;

        w_s0Valid = 1'b0;
        w_s0Data  = w_wrapData;
        w_s0Laps  = w_wrapLaps;
        if (w_accept) begin
            w_s0Valid = 1'b1;
            w_s0Data  = in_data;
            w_s0Laps  = (in_laps == '0) ? LAP_W'(1) : in_laps;
        end else if (w_wrapValid && !w_eject) begin
            w_s0Valid = 1'b1;
        end

        w_occNext = OCC_W'(w_s0Valid);
        for (int i = 0; i < STAGES - 1; i++) begin
            w_occNext = w_occNext + OCC_W'(r_v[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_v[i]    <= 1'b0;
                r_data[i] <= '0;
                r_laps[i] <= '0;
            end
            r_outValid  <= 1'b0;
            r_outData   <= '0;
            r_occupancy <= '0;
        end else begin
            r_v[0]    <= w_s0Valid;
            r_data[0] <= w_s0Data;
            r_laps[0] <= w_s0Laps;
            for (int i = 1; i < STAGES; i++) begin
                r_v[i]    <= r_v[i-1];
                r_data[i] <= r_data[i-1] + WIDTH'(1);
                r_laps[i] <= r_laps[i-1];
            end
            if (w_eject) begin
                r_outValid <= 1'b1;
                r_outData  <= w_wrapData;
            end else if (w_outFree) begin
                r_outValid <= 1'b0;
            end
            r_occupancy <= w_occNext;
        end
    end

    assign in_ready  = !w_wrapValid || ((w_wrapLaps == '0) && w_outFree);
    assign out_valid = r_outValid;
    assign out_data  = r_outData;
    assign occupancy = r_occupancy;

endmodule

// File: tb/tb_ring_recirc_pipeline.sv
// Directed bench for ring_recirc_pipeline: expected payloads go into a queue at injection
// and a monitor pops and compares them on every output handshake.
module tb_ring_recirc_pipeline;

    localparam int WIDTH  = 8;
    localparam int STAGES = 4;
    localparam int LAP_W  = 4;
    localparam int OCC_W  = $clog2(STAGES + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [LAP_W-1:0] in_laps;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [OCC_W-1:0] occupancy;

    logic [WIDTH-1:0] expQ[$];
    int checkCount = 0;
    int passCount  = 0;

    ring_recirc_pipeline #(.WIDTH(WIDTH), .STAGES(STAGES), .LAP_W(LAP_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_laps(in_laps),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Present one packet for a single edge; optionally record its expected output payload.
    task automatic applyStimulus(input logic [WIDTH-1:0] data, input logic [LAP_W-1:0] laps,
                                 input logic [WIDTH-1:0] expected, input bit expectOut);
        in_valid = 1'b1;
        in_data  = data;
        in_laps  = laps;
        checkOutput("in_ready at inject", 32'(in_ready), 32'd1);
        if (expectOut) expQ.push_back(expected);
        tick(1);
        in_valid = 1'b0;
    endtask

    // Monitor samples a little after the falling edge, once the driver has settled inputs.
    always @(negedge clk) begin
        #2;
        if (!rst && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL unexpected output: got 0x%0h, expected no output", out_data);
            end else begin
                checkOutput("scoreboard out_data", 32'(out_data), 32'(expQ.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_laps = '0; out_ready = 1'b1;
        tick(2);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset out_data", 32'(out_data), 32'd0);
        checkOutput("reset occupancy", 32'(occupancy), 32'd0);
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        tick(1);

        // Single lap: 0x10 -> 0x14 four edges later, then output empties.
        applyStimulus(8'h10, 4'd1, 8'h14, 1'b1);
        tick(3);
        checkOutput("L1 out_valid before t+4", 32'(out_valid), 32'd0);
        tick(1);
        checkOutput("L1 out_valid at t+4", 32'(out_valid), 32'd1);
        checkOutput("L1 out_data at t+4", 32'(out_data), 32'h14);
        tick(1);
        checkOutput("L1 out_valid at t+5", 32'(out_valid), 32'd0);

        // Three laps with payload wrap-around: 0xFE + 12 = 0x0A.
        applyStimulus(8'hFE, 4'd3, 8'h0A, 1'b1);
        for (int k = 0; k < 11; k++) begin
            checkOutput("L3 occupancy in transit", 32'(occupancy), 32'd1);
            tick(1);
        end
        checkOutput("L3 out_valid before t+12", 32'(out_valid), 32'd0);
        tick(1);
        checkOutput("L3 out_valid at t+12", 32'(out_valid), 32'd1);
        checkOutput("L3 out_data at t+12", 32'(out_data), 32'h0A);
        checkOutput("L3 occupancy after eject", 32'(occupancy), 32'd0);
        tick(2);

        // Backpressure: B is blocked once and ejects a lap later as 0x28.
        out_ready = 1'b0;
        applyStimulus(8'h00, 4'd1, 8'h04, 1'b1);
        applyStimulus(8'h20, 4'd1, 8'h28, 1'b1);
        tick(3);
        checkOutput("blk A out_valid t+4", 32'(out_valid), 32'd1);
        checkOutput("blk A out_data t+4", 32'(out_data), 32'h04);
        tick(1);
        checkOutput("blk A held t+5", 32'(out_data), 32'h04);
        checkOutput("blk B recirculating", 32'(occupancy), 32'd1);
        out_ready = 1'b1;
        tick(1);
        checkOutput("blk out_valid t+6", 32'(out_valid), 32'd0);
        tick(2);
        checkOutput("blk out_valid t+8", 32'(out_valid), 32'd0);
        tick(1);
        checkOutput("blk B out_valid t+9", 32'(out_valid), 32'd1);
        checkOutput("blk B out_data t+9", 32'(out_data), 32'h28);
        tick(2);

        // Full ring: four L=2 packets, in_ready low while every wrap still has a lap to go.
        applyStimulus(8'h30, 4'd2, 8'h38, 1'b1);
        applyStimulus(8'h40, 4'd2, 8'h48, 1'b1);
        applyStimulus(8'h50, 4'd2, 8'h58, 1'b1);
        applyStimulus(8'h60, 4'd2, 8'h68, 1'b1);
        for (int k = 4; k < 8; k++) begin
            checkOutput("full in_ready", 32'(in_ready), 32'd0);
            tick(1);
            checkOutput("full occupancy", 32'(occupancy), 32'd4);
        end
        for (int k = 8; k < 12; k++) begin
            checkOutput("drain in_ready", 32'(in_ready), 32'd1);
            tick(1);
            checkOutput("drain out_valid", 32'(out_valid), 32'd1);
            checkOutput("drain out_data", 32'(out_data), 32'(8'h38 + 8'((k - 8) * 16)));
            checkOutput("drain occupancy", 32'(occupancy), 32'(11 - k));
        end
        tick(2);

        // Zero laps behaves as one lap.
        applyStimulus(8'h77, 4'd0, 8'h7B, 1'b1);
        tick(3);
        checkOutput("L0 out_valid before t+4", 32'(out_valid), 32'd0);
        tick(1);
        checkOutput("L0 out_valid at t+4", 32'(out_valid), 32'd1);
        checkOutput("L0 out_data at t+4", 32'(out_data), 32'h7B);
        tick(2);

        // Mid-flight reset discards ring contents and the output register.
        out_ready = 1'b0;
        applyStimulus(8'h01, 4'd1, 8'h00, 1'b0);
        applyStimulus(8'h02, 4'd1, 8'h00, 1'b0);
        applyStimulus(8'h03, 4'd1, 8'h00, 1'b0);
        applyStimulus(8'h04, 4'd1, 8'h00, 1'b0);
        tick(1);
        checkOutput("pre-rst out_valid", 32'(out_valid), 32'd1);
        checkOutput("pre-rst occupancy", 32'(occupancy), 32'd3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checkOutput("post-rst out_valid", 32'(out_valid), 32'd0);
        checkOutput("post-rst out_data", 32'(out_data), 32'd0);
        checkOutput("post-rst occupancy", 32'(occupancy), 32'd0);
        checkOutput("post-rst in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            checkOutput("post-rst no output", 32'(out_valid), 32'd0);
        end

        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
